// File: rtl/split_join_ctrl_if.sv
// Handshake/bus bundle for split_join_ctrl: request, response and stack ports.
// slave = controller view, master = requester/scheduler/stack view.
interface split_join_ctrl_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 32,
  parameter int DEPTH       = 4
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int ADDRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRYW   = 2 * NUM_THREADS + PC_BITS;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_is_join;
  logic [NW_WIDTH-1:0]        req_wid;
  logic [NUM_THREADS-1:0]     req_tmask;
  logic [NUM_THREADS-1:0]     req_taken;
  logic [PC_BITS-1:0]         req_else_pc;
  logic [PC_BITS-1:0]         req_join_pc;
  logic [ADDRW-1:0]           req_stack_ptr;

  logic                       rsp_valid;
  logic [NW_WIDTH-1:0]        rsp_wid;
  logic [NUM_THREADS-1:0]     rsp_tmask;
  logic                       rsp_pc_en;
  logic [PC_BITS-1:0]         rsp_pc;
  logic [ADDRW-1:0]           rsp_stack_ptr;

  logic                       stk_push;
  logic                       stk_pop;
  logic [NW_WIDTH-1:0]        stk_wid;
  logic [ENTRYW-1:0]          stk_d_val;
  logic [ADDRW-1:0]           stk_rd_ptr;
  logic [ENTRYW-1:0]          stk_q_val;
  logic                       stk_q_idx;
  logic [NUM_WARPS*ADDRW-1:0] stk_wr_ptr;
  logic                       stk_full;

  modport slave (
    input  req_valid, req_is_join, req_wid, req_tmask,
    input  req_taken, req_else_pc, req_join_pc, req_stack_ptr,
    output req_ready,
    output rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en, rsp_pc,
    output rsp_stack_ptr,
    output stk_push, stk_pop, stk_wid, stk_d_val, stk_rd_ptr,
    input  stk_q_val, stk_q_idx, stk_wr_ptr, stk_full
  );

  modport master (
    output req_valid, req_is_join, req_wid, req_tmask,
    output req_taken, req_else_pc, req_join_pc, req_stack_ptr,
    input  req_ready,
    input  rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en, rsp_pc,
    input  rsp_stack_ptr,
    input  stk_push, stk_pop, stk_wid, stk_d_val, stk_rd_ptr,
    output stk_q_val, stk_q_idx, stk_wr_ptr, stk_full
  );
endinterface

// File: rtl/split_join_ctrl.sv
// SPLIT/JOIN control in front of the per-warp IPDOM stack.
// Ports: clk, reset (async high), bus (slave modport), overflow_err (sticky).
module split_join_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 32,
  parameter int DEPTH       = 4
) (
  input  logic              clk,
  input  logic              reset,
  split_join_ctrl_if.slave  bus,
  output logic              overflow_err
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int ADDRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NT       = NUM_THREADS;

  typedef enum logic {
    S_IDLE,
    S_JOIN_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_split;
  logic                  w_div;
  logic [NT-1:0]         w_else;
  logic [NT-1:0]         w_q_orig;
  logic [NT-1:0]         w_q_else;
  logic [PC_BITS-1:0]    w_q_pc;

  logic [NUM_WARPS-1:0][ADDRW-1:0] w_wr_ptrs;

  logic                  r_rsp_valid;
  logic [NW_WIDTH-1:0]   r_rsp_wid;
  logic [NT-1:0]         r_rsp_tmask;
  logic                  r_rsp_pc_en;
  logic [PC_BITS-1:0]    r_rsp_pc;
  logic [ADDRW-1:0]      r_rsp_ptr;
  logic                  r_ovf;
  logic [NW_WIDTH-1:0]   r_jwid;
  logic [PC_BITS-1:0]    r_jpc;

  assign w_wr_ptrs = bus.stk_wr_ptr;
  assign w_else    = bus.req_tmask & ~bus.req_taken;
  assign w_div     = (|bus.req_taken) & (|w_else);
  assign w_split   = w_ready & bus.req_valid & ~bus.req_is_join;

  assign w_q_orig  = bus.stk_q_val[PC_BITS+2*NT-1 -: NT];
  assign w_q_else  = bus.stk_q_val[PC_BITS+NT-1 -: NT];
  assign w_q_pc    = bus.stk_q_val[PC_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_is_join) begin
            w_pop       = 1'b1;
            w_state_nxt = S_JOIN_WAIT;
          end else begin
            // full stack: divergence is dropped, warp runs uniform
            w_push = w_div & ~bus.stk_full;
          end
        end
      end
      S_JOIN_WAIT: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_wid   <= '0;
      r_rsp_tmask <= '0;
      r_rsp_pc_en <= 1'b0;
      r_rsp_pc    <= '0;
      r_rsp_ptr   <= '0;
      r_ovf       <= 1'b0;
      r_jwid      <= '0;
      r_jpc       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_pop) begin
        r_jwid <= bus.req_wid;
        r_jpc  <= bus.req_join_pc;
      end
      if (w_split) begin
        r_rsp_valid <= 1'b1;
        r_rsp_wid   <= bus.req_wid;
        r_rsp_tmask <= w_push ? bus.req_taken : bus.req_tmask;
        r_rsp_pc_en <= 1'b0;
        r_rsp_pc    <= '0;
        r_rsp_ptr   <= w_wr_ptrs[bus.req_wid];
        if (w_div && bus.stk_full) r_ovf <= 1'b1;
      end
      if (r_state == S_JOIN_WAIT) begin
        // first pop of an entry runs the else path, second restores orig
        r_rsp_valid <= 1'b1;
        r_rsp_wid   <= r_jwid;
        r_rsp_ptr   <= '0;
        if (bus.stk_q_idx) begin
          r_rsp_tmask <= w_q_orig;
          r_rsp_pc_en <= 1'b0;
          r_rsp_pc    <= r_jpc;
        end else begin
          r_rsp_tmask <= w_q_else;
          r_rsp_pc_en <= 1'b1;
          r_rsp_pc    <= w_q_pc;
        end
      end
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.stk_push      = w_push;
  assign bus.stk_pop       = w_pop;
  assign bus.stk_wid       = bus.req_wid;
  assign bus.stk_d_val     = {bus.req_tmask, w_else, bus.req_else_pc};
  assign bus.stk_rd_ptr    = bus.req_stack_ptr;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_wid       = r_rsp_wid;
  assign bus.rsp_tmask     = r_rsp_tmask;
  assign bus.rsp_pc_en     = r_rsp_pc_en;
  assign bus.rsp_pc        = r_rsp_pc;
  assign bus.rsp_stack_ptr = r_rsp_ptr;
  assign overflow_err      = r_ovf;
endmodule

// File: tb/tb_split_join_ctrl.sv
// Directed bench for split_join_ctrl with a small IPDOM stack model.
// Drives on negedge, samples 1ns after posedge.
module tb_split_join_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf;
  logic full_force = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  split_join_ctrl_if #(4, 4, 32, 4) bus ();

  split_join_ctrl #(
    .NUM_WARPS(4), .NUM_THREADS(4), .PC_BITS(32), .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus.slave),
    .overflow_err(ovf)
  );

  // stack model: registered read, entry popped on its second read
  logic [39:0]     mem [4][4];
  logic [3:0][3:0] fl;
  logic [3:0][1:0] wp;

  assign bus.stk_wr_ptr = wp;
  assign bus.stk_full   = full_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp            <= '0;
      fl            <= '0;
      bus.stk_q_val <= '0;
      bus.stk_q_idx <= 1'b0;
    end else if (bus.stk_push) begin
      mem[bus.stk_wid][wp[bus.stk_wid]] <= bus.stk_d_val;
      fl[bus.stk_wid][wp[bus.stk_wid]]  <= 1'b0;
      wp[bus.stk_wid] <= wp[bus.stk_wid] + 2'd1;
    end else if (bus.stk_pop) begin
      bus.stk_q_val <= mem[bus.stk_wid][bus.stk_rd_ptr];
      bus.stk_q_idx <= fl[bus.stk_wid][bus.stk_rd_ptr];
      if (fl[bus.stk_wid][bus.stk_rd_ptr])
        wp[bus.stk_wid] <= bus.stk_rd_ptr;
      else
        fl[bus.stk_wid][bus.stk_rd_ptr] <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic j, input logic [1:0] w,
                         input logic [3:0] tm, input logic [3:0] tk,
                         input logic [31:0] epc, input logic [31:0] jpc,
                         input logic [1:0] p);
    bus.req_valid     = 1'b1;
    bus.req_is_join   = j;
    bus.req_wid       = w;
    bus.req_tmask     = tm;
    bus.req_taken     = tk;
    bus.req_else_pc   = epc;
    bus.req_join_pc   = jpc;
    bus.req_stack_ptr = p;
  endtask

  task automatic do_split(input string tag, input logic [1:0] w,
                          input logic [3:0] tm, input logic [3:0] tk,
                          input logic [31:0] epc, input logic ex_push,
                          input logic [39:0] ex_d, input logic [3:0] ex_tm,
                          input logic [1:0] ex_ptr);
    @(negedge clk);
    set_req(1'b0, w, tm, tk, epc, 32'h0, 2'd0);
    #1;
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, ".push"}, 64'(bus.stk_push), 64'(ex_push));
    if (ex_push) chk({tag, ".dval"}, 64'(bus.stk_d_val), 64'(ex_d));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".rvalid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, ".rwid"}, 64'(bus.rsp_wid), 64'(w));
    chk({tag, ".rtmask"}, 64'(bus.rsp_tmask), 64'(ex_tm));
    chk({tag, ".rpcen"}, 64'(bus.rsp_pc_en), 64'd0);
    chk({tag, ".rptr"}, 64'(bus.rsp_stack_ptr), 64'(ex_ptr));
  endtask

  task automatic do_join(input string tag, input logic [1:0] w,
                         input logic [1:0] p, input logic [31:0] jpc,
                         input logic [3:0] ex_tm, input logic ex_en,
                         input logic [31:0] ex_pc);
    @(negedge clk);
    set_req(1'b1, w, 4'h0, 4'h0, 32'h0, jpc, p);
    #1;
    chk({tag, ".pop"}, 64'(bus.stk_pop), 64'd1);
    chk({tag, ".push"}, 64'(bus.stk_push), 64'd0);
    chk({tag, ".rdptr"}, 64'(bus.stk_rd_ptr), 64'(p));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, ".wready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, ".wvalid"}, 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ".rvalid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, ".rwid"}, 64'(bus.rsp_wid), 64'(w));
    chk({tag, ".rtmask"}, 64'(bus.rsp_tmask), 64'(ex_tm));
    chk({tag, ".rpcen"}, 64'(bus.rsp_pc_en), 64'(ex_en));
    chk({tag, ".rpc"}, 64'(bus.rsp_pc), 64'(ex_pc));
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_is_join   = 1'b0;
    bus.req_wid       = '0;
    bus.req_tmask     = '0;
    bus.req_taken     = '0;
    bus.req_else_pc   = '0;
    bus.req_join_pc   = '0;
    bus.req_stack_ptr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(bus.req_ready), 64'd1);
    chk("rst.rvalid", 64'(bus.rsp_valid), 64'd0);
    chk("rst.push", 64'(bus.stk_push), 64'd0);
    chk("rst.pop", 64'(bus.stk_pop), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    chk("rst.rtmask", 64'(bus.rsp_tmask), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset while waiting on a JOIN read
    @(negedge clk);
    set_req(1'b1, 2'd0, 4'h0, 4'h0, 32'h0, 32'h10, 2'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("jrst.wready", 64'(bus.req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("jrst.rvalid", 64'(bus.rsp_valid), 64'd0);
    chk("jrst.ready", 64'(bus.req_ready), 64'd1);
    chk("jrst.ovf", 64'(ovf), 64'd0);

    do_split("sp1", 2'd1, 4'b1111, 4'b0011, 32'h100, 1'b1,
             {4'b1111, 4'b1100, 32'h100}, 4'b0011, 2'd0);
    do_split("uni1", 2'd2, 4'b1111, 4'b1111, 32'h200, 1'b0,
             40'h0, 4'b1111, 2'd0);
    do_split("uni0", 2'd2, 4'b1111, 4'b0000, 32'h200, 1'b0,
             40'h0, 4'b1111, 2'd0);

    // JOIN held by requester while controller waits on the stack
    @(negedge clk);
    set_req(1'b1, 2'd1, 4'h0, 4'h0, 32'h0, 32'h180, 2'd0);
    #1;
    chk("hj.pop", 64'(bus.stk_pop), 64'd1);
    @(posedge clk);
    #1;
    set_req(1'b1, 2'd1, 4'h0, 4'h0, 32'h0, 32'h180, 2'd0);
    chk("hj.ready", 64'(bus.req_ready), 64'd0);
    chk("hj.nopop", 64'(bus.stk_pop), 64'd0);
    @(posedge clk);
    #1;
    chk("hj1.rvalid", 64'(bus.rsp_valid), 64'd1);
    chk("hj1.rtmask", 64'(bus.rsp_tmask), 64'(4'b1100));
    chk("hj1.rpcen", 64'(bus.rsp_pc_en), 64'd1);
    chk("hj1.rpc", 64'(bus.rsp_pc), 64'h100);
    chk("hj2.ready", 64'(bus.req_ready), 64'd1);
    chk("hj2.pop", 64'(bus.stk_pop), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("hj2.wvalid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("hj2.rvalid", 64'(bus.rsp_valid), 64'd1);
    chk("hj2.rtmask", 64'(bus.rsp_tmask), 64'(4'b1111));
    chk("hj2.rpcen", 64'(bus.rsp_pc_en), 64'd0);
    chk("hj2.rpc", 64'(bus.rsp_pc), 64'h180);

    // nested divergence on warp 0
    do_split("ns0", 2'd0, 4'b1111, 4'b0011, 32'h40, 1'b1,
             {4'b1111, 4'b1100, 32'h40}, 4'b0011, 2'd0);
    do_split("ns1", 2'd0, 4'b0011, 4'b0001, 32'h80, 1'b1,
             {4'b0011, 4'b0010, 32'h80}, 4'b0001, 2'd1);
    do_join("nj1a", 2'd0, 2'd1, 32'h90, 4'b0010, 1'b1, 32'h80);
    do_join("nj1b", 2'd0, 2'd1, 32'h90, 4'b0011, 1'b0, 32'h90);
    do_join("nj0a", 2'd0, 2'd0, 32'hA0, 4'b1100, 1'b1, 32'h40);
    do_join("nj0b", 2'd0, 2'd0, 32'hA0, 4'b1111, 1'b0, 32'hA0);

    // divergent SPLIT against a full stack
    chk("pre.ovf", 64'(ovf), 64'd0);
    full_force = 1'b1;
    do_split("full", 2'd3, 4'b1111, 4'b0101, 32'h300, 1'b0,
             40'h0, 4'b1111, 2'd0);
    chk("full.ovf", 64'(ovf), 64'd1);
    full_force = 1'b0;
    do_split("post", 2'd3, 4'b0110, 4'b0110, 32'h300, 1'b0,
             40'h0, 4'b0110, 2'd0);
    chk("post.ovf", 64'(ovf), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/split_join_ctrl.md
Name: split_join_ctrl

Overview:
Control stage directly upstream of the per-warp IPDOM stack. Accepts SPLIT and JOIN requests from the warp-control path, decides divergence, drives the stack's push/pop/rd_ptr/d_val interface, and returns the warp's updated thread mask and next PC to the scheduler. It absorbs the stack's one-cycle registered read latency with a small FSM.

Parameters:
NUM_WARPS, 4, warps sharing the stack; NW_WIDTH = LOG2UP(NUM_WARPS)
NUM_THREADS, 4, threads per warp (mask width)
PC_BITS, 32, PC width
DEPTH, 4, stack entries per warp
ADDRW, LOG2UP(DEPTH), stack pointer width
ENTRYW, 2*NUM_THREADS+PC_BITS, stack entry {orig_tmask, else_tmask, else_pc}

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_is_join  in  1  0=SPLIT, 1=JOIN
req_wid  in  NW_WIDTH  requesting warp
req_tmask  in  NUM_THREADS  current warp thread mask
req_taken  in  NUM_THREADS  SPLIT predicate mask (subset of req_tmask)
req_else_pc  in  PC_BITS  SPLIT else-path PC
req_join_pc  in  PC_BITS  PC following the JOIN instruction
req_stack_ptr  in  ADDRW  JOIN: pointer returned by matching SPLIT
rsp_valid  out  1  one-cycle update pulse
rsp_wid  out  NW_WIDTH  warp being updated
rsp_tmask  out  NUM_THREADS  new thread mask
rsp_pc_en  out  1  1=redirect warp to rsp_pc
rsp_pc  out  PC_BITS  redirect target
rsp_stack_ptr  out  ADDRW  SPLIT: pointer for the later JOIN
stk_push  out  1  stack push
stk_pop  out  1  stack pop
stk_wid  out  NW_WIDTH  stack warp select
stk_d_val  out  ENTRYW  push data
stk_rd_ptr  out  ADDRW  pop/read pointer
stk_q_val  in  ENTRYW  read data (valid cycle after pop)
stk_q_idx  in  1  0=first pop of entry, 1=second
stk_wr_ptr  in  NUM_WARPS*ADDRW  per-warp write pointers
stk_full  in  1  full flag of stk_wid
overflow_err  out  1  sticky: divergent SPLIT hit full stack

Behaviour:
- Reset (async assert): FSM=IDLE, req_ready=1, rsp_valid=0, stk_push=0, stk_pop=0, overflow_err=0, all registered outputs 0.
- FSM states: IDLE, JOIN_WAIT.
- IDLE, SPLIT accepted: else_mask = req_tmask & ~req_taken.
  - Divergent (req_taken != 0 and else_mask != 0): stk_push=1 same cycle (combinational from accepted request), stk_wid=req_wid, stk_d_val={req_tmask, else_mask, req_else_pc}; next cycle rsp_valid=1, rsp_tmask=req_taken, rsp_pc_en=0, rsp_stack_ptr=stk_wr_ptr[req_wid] sampled at accept.
  - Uniform: no push; next cycle rsp_valid=1, rsp_tmask=req_tmask, rsp_pc_en=0, rsp_stack_ptr=stk_wr_ptr[req_wid].
  - Divergent with stk_full=1: no push, overflow_err set (sticky to reset), response as uniform.
  - FSM remains IDLE; back-to-back SPLITs accepted every cycle.
- IDLE, JOIN accepted: stk_pop=1, stk_rd_ptr=req_stack_ptr, stk_wid=req_wid; latch wid and join_pc; go JOIN_WAIT; req_ready=0 in JOIN_WAIT.
- JOIN_WAIT (exactly one cycle): sample stk_q_val/stk_q_idx; next cycle rsp_valid=1, return to IDLE.
  - q_idx=0: rsp_tmask=else_tmask, rsp_pc_en=1, rsp_pc=else_pc.
  - q_idx=1: rsp_tmask=orig_tmask, rsp_pc_en=0 (continue at join_pc; rsp_pc=join_pc).
- Latency: SPLIT request->rsp 1 cycle; JOIN request->rsp 2 cycles; JOIN throughput 1 per 2 cycles.
- Never push and pop in the same cycle; stk_push/stk_pop are one-cycle pulses.
- rsp_valid is a pulse; no backpressure on response.
- Reset asserted in JOIN_WAIT: FSM->IDLE, pending response dropped, no rsp_valid.

Test Plan:
- Reset mid-JOIN_WAIT -> rsp_valid stays 0, req_ready=1 next cycle, overflow_err=0.
- SPLIT wid=1, tmask=4'b1111, taken=4'b0011, else_pc=0x100, wr_ptr[1]=0 -> stk_push=1, d_val={1111,1100,0x100}; next cycle rsp_tmask=0011, rsp_stack_ptr=0, rsp_pc_en=0.
- Uniform SPLIT taken=4'b1111 (and taken=0000) -> stk_push=0, rsp_tmask=1111.
- JOIN wid=1 ptr=0 with q_idx=0 -> stk_pop=1, 2 cycles later rsp_tmask=1100, rsp_pc_en=1, rsp_pc=0x100; second JOIN with q_idx=1 -> rsp_tmask=1111, rsp_pc_en=0.
- Nested: two divergent SPLITs wid=0 -> rsp_stack_ptr 0 then 1; JOINs with ptr 1 then 0 restore inner then outer masks.
- Divergent SPLIT with stk_full=1 -> no push, overflow_err=1 and stays 1; req_valid during JOIN_WAIT -> req_ready=0, request held.
